// File: rtl/demux_8_buffered.sv
// rtl/demux_8_buffered.sv - one producer steered into eight one-entry output slots, each with its own valid/ready
// Optional DEMUX8_BROADCAST_EN adds in_broadcast, which loads all eight slots with one word.
module demux_8_buffered #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_select,
  input  logic [WIDTH-1:0]     in_data,
`ifdef DEMUX8_BROADCAST_EN
  input  logic                 in_broadcast,
`endif
  output logic [7:0]           out_valid,
  input  logic [7:0]           out_ready,
  output logic [8*WIDTH-1:0]   out_data,
  output logic [3:0]           occupancy
);

  logic [7:0]       valid_q, valid_d;
  logic [WIDTH-1:0] slot_q [8];
  logic [WIDTH-1:0] slot_d [8];
  logic [3:0]       occ_q, occ_d;
  logic [7:0]       fill;
  logic             bcast;

`ifdef DEMUX8_BROADCAST_EN
  assign bcast = in_broadcast;
`else
  assign bcast = 1'b0;
`endif

  // A slot can take a new word when empty or when its consumer drains it this same edge.
  always_comb begin
    in_ready = 1'b0;
    fill     = 8'h00;
    valid_d  = valid_q;
    occ_d    = 4'd0;
    if (bcast) begin
      in_ready = &(~valid_q | out_ready);
    end else begin
      in_ready = ~valid_q[in_select] | out_ready[in_select];
    end
    if (in_valid && in_ready) begin
      fill = bcast ? 8'hFF : (8'h01 << in_select);
    end
    valid_d = (valid_q & ~out_ready) | fill;
    for (int i = 0; i < 8; i++) begin
      slot_d[i] = fill[i] ? in_data : slot_q[i];
      occ_d     = occ_d + {3'b000, valid_d[i]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 8'h00;
      occ_q   <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < 8; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < 8; i++) begin
      out_data[i*WIDTH +: WIDTH] = slot_q[i];
    end
  end

  assign out_valid = valid_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_demux_8_buffered.sv
// tb/tb_demux_8_buffered.sv - directed self-checking bench for demux_8_buffered
module tb_demux_8_buffered;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_select;
  logic [31:0]  in_data;
`ifdef DEMUX8_BROADCAST_EN
  logic         in_broadcast;
`endif
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [255:0] out_data;
  logic [3:0]   occupancy;

  int vectors;
  int miscompares;

  demux_8_buffered #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_select   (in_select),
    .in_data     (in_data),
`ifdef DEMUX8_BROADCAST_EN
    .in_broadcast(in_broadcast),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .occupancy   (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_select   = 3'd0;
    in_data     = 32'h0;
    out_ready   = 8'h00;
`ifdef DEMUX8_BROADCAST_EN
    in_broadcast = 1'b0;
`endif
    step();
    step();
    check("rst_valid", out_valid, 8'h00);
    check("rst_occ", occupancy, 4'd0);
    check("rst_data", out_data, 256'h0);
    check("rst_ready", in_ready, 1'b1);
    reset = 1'b0;
    step();

    // Single write to slot 3, then a blocked second write.
    in_valid = 1'b1; in_select = 3'd3; in_data = 32'hDEADBEEF;
    #1 check("w3_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    #1;
    check("w3_valid", out_valid, 8'h08);
    check("w3_data", out_data[127:96], 32'hDEADBEEF);
    check("w3_occ", occupancy, 4'd1);
    in_valid = 1'b1; in_data = 32'h11111111;
    #1 check("w3_blocked", in_ready, 1'b0);
    in_select = 3'd2;
    #1 check("w2_free", in_ready, 1'b1);
    in_select = 3'd3;
    step();
    check("w3_kept", out_data[127:96], 32'hDEADBEEF);
    check("w3_kept_valid", out_valid, 8'h08);

    // Same-slot drain and refill, no bubble.
    out_ready = 8'h08; in_data = 32'h12345678;
    #1;
    check("df_ready", in_ready, 1'b1);
    check("df_old", out_data[127:96], 32'hDEADBEEF);
    step();
    in_valid = 1'b0;
    #1;
    check("df_new", out_data[127:96], 32'h12345678);
    check("df_valid", out_valid, 8'h08);
    check("df_occ", occupancy, 4'd1);
    step();
    out_ready = 8'h00;
    #1;
    check("drain3_valid", out_valid, 8'h00);
    check("drain3_occ", occupancy, 4'd0);
    check("drain3_hold", out_data[127:96], 32'h12345678);

    // Fill all eight back-to-back.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_select = i[2:0]; in_data = 32'hC0DE0000 + i;
      step();
      check($sformatf("fill_occ%0d", i), occupancy, i + 1);
    end
    in_valid = 1'b0; in_select = 3'd5;
    #1;
    check("full_valid", out_valid, 8'hFF);
    check("full_ready", in_ready, 1'b0);
    check("full_slot6", out_data[223:192], 32'hC0DE0006);
    check("full_slot0", out_data[31:0], 32'hC0DE0000);
    out_ready = 8'hFF;
    step();
    out_ready = 8'h00;
    #1;
    check("empty_valid", out_valid, 8'h00);
    check("empty_occ", occupancy, 4'd0);

    // Fill slot 0 while slot 7 drains.
    in_valid = 1'b1; in_select = 3'd7; in_data = 32'h77777777;
    step();
    check("s7_valid", out_valid, 8'h80);
    in_select = 3'd0; in_data = 32'h0A0A0A0A; out_ready = 8'h80;
    step();
    in_valid = 1'b0; out_ready = 8'h00;
    #1;
    check("x_valid", out_valid, 8'h01);
    check("x_occ", occupancy, 4'd1);
    check("x_data0", out_data[31:0], 32'h0A0A0A0A);
    step();

    // Asynchronous reset mid-cycle with slots 2 and 5 full.
    out_ready = 8'h01;
    step();
    out_ready = 8'h00;
    in_valid = 1'b1; in_select = 3'd2; in_data = 32'h22222222;
    step();
    in_select = 3'd5; in_data = 32'h55555555;
    step();
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", out_valid, 8'h24);
    check("pre_rst_occ", occupancy, 4'd2);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 8'h00);
    check("arst_occ", occupancy, 4'd0);
    check("arst_data", out_data, 256'h0);
    check("arst_ready5", in_ready, 1'b1);
    in_select = 3'd2;
    #1 check("arst_ready2", in_ready, 1'b1);
    step();
    reset = 1'b0;
    step();

`ifdef DEMUX8_BROADCAST_EN
    in_valid = 1'b1; in_select = 3'd4; in_data = 32'h44444444;
    step();
    in_broadcast = 1'b1; in_select = 3'd0; in_data = 32'hA5A5A5A5;
    #1 check("bc_blocked", in_ready, 1'b0);
    step();
    check("bc_held_valid", out_valid, 8'h10);
    out_ready = 8'h10;
    #1 check("bc_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; in_broadcast = 1'b0; out_ready = 8'h00;
    #1;
    check("bc_valid", out_valid, 8'hFF);
    check("bc_occ", occupancy, 4'd8);
    check("bc_data", out_data, {8{32'hA5A5A5A5}});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
